// File: rtl/m_ai_turn_sequencer.sv
// CPU turn sequencer around the game-tree search: latch board, launch search,
// validate the returned column (or fall back), and apply the move.
module m_ai_turn_sequencer #(
  parameter int NUM_COLS = 7,
  parameter int NUM_ROWS = 6,
  parameter int FIELD_W  = 42,
  parameter int CNT_W    = 3,
  parameter int COL_W    = 3,
  parameter int TIMEOUT  = 1000000
) (
  input  logic                      w_clk,
  input  logic                      w_rst,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [FIELD_W-1:0]        i_me_field,
  input  logic [FIELD_W-1:0]        i_op_field,
  input  logic [NUM_COLS*CNT_W-1:0] i_piled_array,
  output logic                      o_tree_en,
  output logic                      o_tree_rst,
  output logic [FIELD_W-1:0]        o_tree_me_field,
  output logic [FIELD_W-1:0]        o_tree_op_field,
  output logic [NUM_COLS*CNT_W-1:0] o_tree_piled_array,
  input  logic                      i_tree_valid,
  input  logic                      i_tree_finished,
  input  logic [COL_W-1:0]          i_tree_col,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [COL_W-1:0]          o_col,
  output logic [1:0]                o_status,
  output logic [FIELD_W-1:0]        o_me_field_next,
  output logic [NUM_COLS*CNT_W-1:0] o_piled_array_next
);

  // state  | meaning
  // IDLE   | waiting for i_start
  // LAUNCH | o_tree_en pulse, counter cleared
  // WAIT   | search running, timeout counter active
  // CHECK  | validate captured column
  // APPLY  | result registers valid, o_done pulse
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_APPLY  = 3'd4;

  localparam int               PILE_W   = NUM_COLS * CNT_W;
  localparam logic [31:0]      CNT_LAST = 32'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ROWS_C   = CNT_W'(NUM_ROWS);

  logic [2:0]         state_q, state_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [COL_W-1:0]   tcol_q;
  logic [FIELD_W-1:0] me_next_d;
  logic [PILE_W-1:0]  piled_next_d;
  logic [COL_W-1:0]   fb_col, apply_col;
  logic [1:0]         status_d;
  logic               fb_found, tcol_ok, in_full, latch, load_res, tree_rst;

  always_comb begin
    in_full  = 1'b1;
    fb_col   = '0;
    fb_found = 1'b0;
    tcol_ok  = 1'b0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (i_piled_array[c*CNT_W +: CNT_W] < ROWS_C) in_full = 1'b0;
      if (!fb_found && o_tree_piled_array[c*CNT_W +: CNT_W] < ROWS_C) begin
        fb_col   = COL_W'(c);
        fb_found = 1'b1;
      end
      if (tcol_q == COL_W'(c) && o_tree_piled_array[c*CNT_W +: CNT_W] < ROWS_C) tcol_ok = 1'b1;
    end
  end

  // Move application: drop the stone on top of the chosen column's pile.
  always_comb begin
    apply_col    = (state_q == S_CHECK && tcol_ok) ? tcol_q : fb_col;
    me_next_d    = o_tree_me_field;
    piled_next_d = o_tree_piled_array;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (apply_col == COL_W'(c)) begin
        piled_next_d[c*CNT_W +: CNT_W] = o_tree_piled_array[c*CNT_W +: CNT_W] + CNT_W'(1);
        for (int r = 0; r < NUM_ROWS; r++) begin
          if (o_tree_piled_array[c*CNT_W +: CNT_W] == CNT_W'(r)) me_next_d[c*NUM_ROWS + r] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    status_d = 2'b00;
    latch    = 1'b0;
    load_res = 1'b0;
    tree_rst = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          latch   = 1'b1;
          state_d = in_full ? S_APPLY : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d = '0;
        if (i_abort) begin
          tree_rst = 1'b1;
          state_d  = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
        if (i_abort) begin
          tree_rst = 1'b1;
          state_d  = S_IDLE;
        end else if (i_tree_valid && i_tree_finished) begin
          state_d = S_CHECK;
        end else if (cnt_q == CNT_LAST) begin
          tree_rst = 1'b1;
          status_d = 2'b11;
          load_res = 1'b1;
          state_d  = S_APPLY;
        end
      end
      S_CHECK: begin
        if (i_abort) begin
          tree_rst = 1'b1;
          state_d  = S_IDLE;
        end else begin
          status_d = tcol_ok ? 2'b00 : 2'b01;
          load_res = 1'b1;
          state_d  = S_APPLY;
        end
      end
      S_APPLY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q            <= S_IDLE;
      cnt_q              <= '0;
      tcol_q             <= '0;
      o_tree_me_field    <= '0;
      o_tree_op_field    <= '0;
      o_tree_piled_array <= '0;
      o_col              <= '0;
      o_status           <= '0;
      o_me_field_next    <= '0;
      o_piled_array_next <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        o_tree_me_field    <= i_me_field;
        o_tree_op_field    <= i_op_field;
        o_tree_piled_array <= i_piled_array;
      end
      if (state_q == S_WAIT && i_tree_valid && i_tree_finished) tcol_q <= i_tree_col;
      // A full board skips the search; the result is the untouched input board.
      if (latch && in_full) begin
        o_col              <= '0;
        o_status           <= 2'b10;
        o_me_field_next    <= i_me_field;
        o_piled_array_next <= i_piled_array;
      end else if (load_res) begin
        o_col              <= apply_col;
        o_status           <= status_d;
        o_me_field_next    <= me_next_d;
        o_piled_array_next <= piled_next_d;
      end
    end
  end

  assign o_tree_en  = (state_q == S_LAUNCH);
  assign o_tree_rst = tree_rst;
  assign o_busy     = (state_q != S_IDLE);
  assign o_done     = (state_q == S_APPLY);

endmodule
